// File: rtl/decimacao_stream_if.sv
// rtl/decimacao_stream_if.sv - pixel input and reduced-pixel output handshake bundle
interface decimacao_stream_if #(
  parameter int PIX_W = 8
) ();
  logic [PIX_W-1:0] in_pixel;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_pixel, out_valid, out_last
  );

  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_pixel, out_valid, out_last
  );
endinterface

// File: rtl/decimacao_stream.sv
// rtl/decimacao_stream.sv - streaming FATORxFATOR block decimator (average/nearest/max/min)
// Keeps one accumulator per block column; one registered output with valid/ready.
module decimacao_stream #(
  parameter int PIX_W   = 8,
  parameter int LARGURA = 4,
  parameter int ALTURA  = 4,
  parameter int FATOR   = 2,
  parameter int ACC_W   = PIX_W + 2 * $clog2(FATOR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           modo,
  output logic                 ocupado,
  decimacao_stream_if.slave    bus
);

  localparam int LOG_F = $clog2(FATOR);
  localparam int NB    = LARGURA / FATOR;
  localparam int XW    = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam int YW    = (ALTURA > 1) ? $clog2(ALTURA) : 1;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {OCIOSO, ATIVO} estado_t;

  estado_t           r_state;
  estado_t           w_state_next;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [1:0]        r_modo_q;
  logic [ACC_W-1:0]  r_acc [NB];
  logic [PIX_W-1:0]  r_out_pixel;
  logic              r_out_valid;
  logic              r_out_last;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_x_end;
  logic              w_y_end;
  logic              w_frame_start;
  logic              w_first;
  logic              w_done;
  logic [LOG_F-1:0]  w_dx;
  logic [LOG_F-1:0]  w_dy;
  logic [BW-1:0]     w_bx;
  logic [ACC_W-1:0]  w_pix_ext;
  logic [ACC_W-1:0]  w_acc_cur;
  logic [ACC_W-1:0]  w_comb;
  logic [ACC_W-1:0]  w_new;
  logic [PIX_W-1:0]  w_result;

  assign bus.in_ready  = !r_out_valid || bus.out_ready;
  assign bus.out_pixel = r_out_pixel;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign ocupado       = (r_state == ATIVO);

  assign w_in_xfer     = bus.in_valid && bus.in_ready;
  assign w_out_xfer    = r_out_valid && bus.out_ready;
  assign w_x_end       = (r_x == XW'(LARGURA - 1));
  assign w_y_end       = (r_y == YW'(ALTURA - 1));
  assign w_frame_start = (r_x == '0) && (r_y == '0);
  assign w_dx          = r_x[LOG_F-1:0];
  assign w_dy          = r_y[LOG_F-1:0];
  assign w_bx          = BW'(r_x >> LOG_F);
  assign w_first       = (w_dx == '0) && (w_dy == '0);
  assign w_done        = (w_dx == LOG_F'(FATOR - 1)) && (w_dy == LOG_F'(FATOR - 1));
  assign w_pix_ext     = ACC_W'(bus.in_pixel);

  // Combined value includes the current pixel, so the completing transfer yields the result directly.
  always_comb begin
    w_acc_cur = r_acc[w_bx];
    w_comb    = w_acc_cur;
    case (r_modo_q)
      2'b00:   w_comb = w_acc_cur + w_pix_ext;
      2'b01:   w_comb = w_acc_cur;
      2'b10:   if (w_pix_ext > w_acc_cur) w_comb = w_pix_ext;
      default: if (w_pix_ext < w_acc_cur) w_comb = w_pix_ext;
    endcase
    w_new = w_first ? w_pix_ext : w_comb;
    if (r_modo_q == 2'b00) begin
      w_result = PIX_W'(w_comb >> (2 * LOG_F));
    end else begin
      w_result = w_comb[PIX_W-1:0];
    end
  end

  // A first pixel arriving alongside the out_last transfer keeps the engine busy.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      OCIOSO:  if (w_in_xfer) w_state_next = ATIVO;
      ATIVO:   if (w_out_xfer && r_out_last && !w_in_xfer) w_state_next = OCIOSO;
      default: w_state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OCIOSO;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_modo_q <= 2'b00;
    end else if (w_in_xfer) begin
      if (w_frame_start) r_modo_q <= modo;
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) r_acc[i] <= '0;
    end else if (w_in_xfer) begin
      r_acc[w_bx] <= w_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_pixel <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_in_xfer && w_done) begin
      r_out_pixel <= w_result;
      r_out_valid <= 1'b1;
      r_out_last  <= w_x_end && w_y_end;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

endmodule
